// File: rtl/load_store_unit_if.sv
// Core-request, response and native memory-bus signals of the load/store unit.
// The slave modport is the unit's view; the master modport is the core/memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: aligns store data into byte lanes, runs one native-bus
// transaction at a time, and returns sign/zero-extended load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd0
) (
    input logic              clk,
    input logic              resetn,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 32'd1;

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic        store_q, store_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] cnt_q, cnt_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    function automatic logic req_err_f(input logic st, input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = off[0];
            3'b010:  bad = (off != 2'b00);
            3'b100:  bad = st;
            3'b101:  bad = st | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] store_data_f(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_strb_f(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] r;
        case (f3[1:0])
            2'b00:   r = 4'b0001 << off;
            2'b01:   r = off[1] ? 4'b1100 : 4'b0011;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext_f(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[8*off +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = rd;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            store_q      <= 1'b0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            cnt_q        <= 32'd0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_wstrb_q  <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            store_q      <= store_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Next-state and next-output logic; response fields default to a one-cycle pulse
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        f3_d         = f3_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    store_d = bus.req_store;
                    f3_d    = bus.req_funct3;
                    off_d   = bus.req_addr[1:0];
                    if (req_err_f(bus.req_store, bus.req_funct3, bus.req_addr[1:0])) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = S_MEM;
                        cnt_d       = 32'd0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wdata_d = bus.req_store ? store_data_f(bus.req_funct3, bus.req_wdata) : 32'd0;
                        mem_wstrb_d = bus.req_store ? store_strb_f(bus.req_funct3, bus.req_addr[1:0]) : 4'd0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MEM: begin
                // A completing mem_ready takes priority over the timeout limit
                if (bus.mem_ready) begin
                    state_d      = S_RESP;
                    mem_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = store_q ? 32'd0 : load_ext_f(f3_q, off_q, bus.mem_rdata);
                end else if ((TIMEOUT_CYCLES != 32'd0) && (cnt_q == TO_LAST)) begin
                    state_d      = S_RESP;
                    mem_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    assign bus.req_ready  = ready_q;
    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wstrb  = mem_wstrb_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench: two units (no timeout, timeout=4) share one stimulus stream and
// are compared against a byte-lane arithmetic model of each access.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        req_valid_s, req_store_s, mem_ready_s;
    logic [2:0]  req_funct3_s;
    logic [31:0] req_addr_s, req_wdata_s, mem_rdata_s;

    load_store_unit_if if0 ();
    load_store_unit_if if4 ();

    load_store_unit #(.TIMEOUT_CYCLES(0)) dut0 (.clk(clk), .resetn(resetn), .bus(if0.slave));
    load_store_unit #(.TIMEOUT_CYCLES(4)) dut4 (.clk(clk), .resetn(resetn), .bus(if4.slave));

    assign if0.req_valid = req_valid_s;   assign if4.req_valid = req_valid_s;
    assign if0.req_store = req_store_s;   assign if4.req_store = req_store_s;
    assign if0.req_funct3 = req_funct3_s; assign if4.req_funct3 = req_funct3_s;
    assign if0.req_addr = req_addr_s;     assign if4.req_addr = req_addr_s;
    assign if0.req_wdata = req_wdata_s;   assign if4.req_wdata = req_wdata_s;
    assign if0.mem_ready = mem_ready_s;   assign if4.mem_ready = mem_ready_s;
    assign if0.mem_rdata = mem_rdata_s;   assign if4.mem_rdata = mem_rdata_s;

    logic        mv [2], rv [2], re [2], rdy [2];
    logic [31:0] ma [2], mwd [2], rd [2];
    logic [3:0]  mws [2];
    assign mv[0] = if0.mem_valid;   assign mv[1] = if4.mem_valid;
    assign rv[0] = if0.resp_valid;  assign rv[1] = if4.resp_valid;
    assign re[0] = if0.resp_err;    assign re[1] = if4.resp_err;
    assign rdy[0] = if0.req_ready;  assign rdy[1] = if4.req_ready;
    assign ma[0] = if0.mem_addr;    assign ma[1] = if4.mem_addr;
    assign mwd[0] = if0.mem_wdata;  assign mwd[1] = if4.mem_wdata;
    assign mws[0] = if0.mem_wstrb;  assign mws[1] = if4.mem_wstrb;
    assign rd[0] = if0.resp_rdata;  assign rd[1] = if4.resp_rdata;

    int total = 0;
    int bad = 0;

    int          mv_cnt [2], resp_cnt [2], bad_stable [2], bad_idle [2], bad_ready [2];
    logic [31:0] cap_addr [2], cap_wdata [2], cap_rdata [2];
    logic [3:0]  cap_wstrb [2];
    logic        cap_err [2];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Per-cycle observation of both units, sampled on the falling edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mv[i] === 1'b1) begin
                if (mv_cnt[i] == 0) begin
                    cap_addr[i]  = ma[i];
                    cap_wdata[i] = mwd[i];
                    cap_wstrb[i] = mws[i];
                end else if (ma[i] !== cap_addr[i] || mwd[i] !== cap_wdata[i] || mws[i] !== cap_wstrb[i]) begin
                    bad_stable[i]++;
                end
                mv_cnt[i]++;
            end
            if (rv[i] === 1'b1) begin
                resp_cnt[i]++;
                cap_rdata[i] = rd[i];
                cap_err[i]   = re[i];
            end else if (rd[i] !== 32'd0 || re[i] !== 1'b0) begin
                bad_idle[i]++;
            end
            if (rdy[i] === 1'b1 && (mv[i] === 1'b1 || rv[i] === 1'b1)) bad_ready[i]++;
        end
    end

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            mv_cnt[i] = 0; resp_cnt[i] = 0; bad_stable[i] = 0; bad_idle[i] = 0; bad_ready[i] = 0;
        end
    endtask

    // Reference: access size from funct3, lanes and extension computed arithmetically
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr, wd, rdata,
                         input int d, input int t, output int e_mv, output logic e_err,
                         output logic [31:0] e_rdata, output logic [31:0] e_wdata, output logic [3:0] e_wstrb);
        int     size, off;
        logic   illegal;
        longint v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off  = int'(addr % 32'd4);
        illegal = (f3 == 3'd3) || (f3 >= 3'd6) || (st && f3 >= 3'd4) || ((addr % 32'(size)) != 32'd0);
        e_wstrb = st ? 4'(((1 << size) - 1) << off) : 4'd0;
        for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = wd[8*(i % size) +: 8];
        v = longint'(rdata >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
        if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v - (64'sd1 <<< (8 * size));
        if (illegal) begin
            e_mv = 0; e_err = 1'b1; e_rdata = 32'd0;
        end else if (t > 0 && d >= t) begin
            e_mv = t; e_err = 1'b1; e_rdata = 32'd0;
        end else begin
            e_mv = d + 1; e_err = 1'b0; e_rdata = st ? 32'd0 : v[31:0];
        end
    endtask

    task automatic run_txn(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat, input int d);
        int          e_mv [2];
        logic        e_err [2];
        logic [31:0] e_rdata [2], e_wdata [2];
        logic [3:0]  e_wstrb [2];
        for (int i = 0; i < 2; i++)
            model(st, f3, addr, wd, rdat, d, i * 4, e_mv[i], e_err[i], e_rdata[i], e_wdata[i], e_wstrb[i]);
        @(posedge clk); #1;
        clear_mon();
        req_valid_s = 1'b1; req_store_s = st; req_funct3_s = f3; req_addr_s = addr; req_wdata_s = wd;
        mem_rdata_s = rdat; mem_ready_s = 1'b0;
        @(posedge clk); #1;
        req_valid_s = 1'b0; req_store_s = 1'($urandom); req_funct3_s = 3'($urandom);
        req_addr_s = $urandom; req_wdata_s = $urandom;
        mem_ready_s = (d == 0);
        for (int k = 1; k <= d + 4; k++) begin
            @(posedge clk); #1;
            mem_ready_s = (k == d);
        end
        mem_ready_s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_value($sformatf("%s/t%0d/mv_cycles", tag, i * 4), 32'(mv_cnt[i]), 32'(e_mv[i]));
            check_value($sformatf("%s/t%0d/resp_pulses", tag, i * 4), 32'(resp_cnt[i]), 32'd1);
            check_value($sformatf("%s/t%0d/err", tag, i * 4), 32'(cap_err[i]), 32'(e_err[i]));
            check_value($sformatf("%s/t%0d/rdata", tag, i * 4), cap_rdata[i], e_rdata[i]);
            if (e_mv[i] > 0) begin
                check_value($sformatf("%s/t%0d/addr", tag, i * 4), cap_addr[i], addr - (addr % 32'd4));
                check_value($sformatf("%s/t%0d/wstrb", tag, i * 4), 32'(cap_wstrb[i]), 32'(e_wstrb[i]));
                if (st) check_value($sformatf("%s/t%0d/wdata", tag, i * 4), cap_wdata[i], e_wdata[i]);
            end
            check_value($sformatf("%s/t%0d/bus_stable", tag, i * 4), 32'(bad_stable[i]), 32'd0);
            check_value($sformatf("%s/t%0d/idle_resp_zero", tag, i * 4), 32'(bad_idle[i]), 32'd0);
            check_value($sformatf("%s/t%0d/ready_when_busy", tag, i * 4), 32'(bad_ready[i]), 32'd0);
            check_value($sformatf("%s/t%0d/ready_after", tag, i * 4), 32'(rdy[i]), 32'd1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_value($sformatf("%s/t%0d/req_ready", tag, i * 4), 32'(rdy[i]), 32'd1);
            check_value($sformatf("%s/t%0d/mem_valid", tag, i * 4), 32'(mv[i]), 32'd0);
            check_value($sformatf("%s/t%0d/resp_valid", tag, i * 4), 32'(rv[i]), 32'd0);
            check_value($sformatf("%s/t%0d/resp_err", tag, i * 4), 32'(re[i]), 32'd0);
            check_value($sformatf("%s/t%0d/resp_rdata", tag, i * 4), rd[i], 32'd0);
            check_value($sformatf("%s/t%0d/mem_addr", tag, i * 4), ma[i], 32'd0);
            check_value($sformatf("%s/t%0d/mem_wdata", tag, i * 4), mwd[i], 32'd0);
            check_value($sformatf("%s/t%0d/mem_wstrb", tag, i * 4), 32'(mws[i]), 32'd0);
        end
    endtask

    initial begin
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        req_valid_s = 1'b0; req_store_s = 1'b0; req_funct3_s = 3'd0; req_addr_s = 32'd0;
        req_wdata_s = 32'd0; mem_ready_s = 1'b0; mem_rdata_s = 32'd0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        check_reset_state("reset");
        clear_mon();

        run_txn("sw_late", 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 2);
        run_txn("lb", 1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_FF7F, 0);
        run_txn("lbu", 1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_FF7F, 1);
        run_txn("sh", 1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 32'h0, 1);
        run_txn("lw_misal", 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1234_5678, 0);
        run_txn("sbu_illegal", 1'b1, 3'b100, 32'h0000_0040, 32'h55, 32'h0, 0);
        run_txn("f3_111", 1'b0, 3'b111, 32'h0000_0040, 32'h0, 32'h0, 0);
        run_txn("lw_stall", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 6);
        run_txn("lhu_b2b", 1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_0000, 0);
        run_txn("lw_limit", 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h0BAD_CAFE, 3);
        run_txn("lw_over", 1'b0, 3'b010, 32'h0000_0048, 32'h0, 32'h0BAD_CAFE, 4);

        // Reset while the bus access is outstanding
        @(posedge clk); #1;
        clear_mon();
        req_valid_s = 1'b1; req_store_s = 1'b0; req_funct3_s = 3'b010; req_addr_s = 32'h40;
        @(posedge clk); #1;
        req_valid_s = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_value($sformatf("midreset/t%0d/resp_pulses", i * 4), 32'(resp_cnt[i]), 32'd0);
            check_value($sformatf("midreset/t%0d/mem_valid", i * 4), 32'(mv[i]), 32'd0);
            check_value($sformatf("midreset/t%0d/req_ready", i * 4), 32'(rdy[i]), 32'd1);
        end

        for (int n = 0; n < 160; n++) begin
            st   = 1'($urandom);
            f3   = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(3) != 0) begin
                if (f3[1:0] == 2'd1) addr[0] = 1'b0;
                if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
            end
            run_txn($sformatf("rnd%0d", n), st, f3, addr, $urandom, $urandom, int'($urandom_range(6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
